fib_stream: RTL

Parametrised Fibonacci sequence source with a valid/ready output stream. It generalises the fixed 8-bit, two-register, single-enable generator to a configurable width with loadable seeds, wrap or saturate overflow handling, a sticky overflow flag and a beat counter. It sits at the top of a datapath as a self-timed test/pattern source feeding any valid/ready consumer.

---
 rtl/fib_pkg.sv | 15 +
 rtl/fib_step.sv | 52 +++++
 rtl/fib_stream.sv | 104 ++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci stream source.
//   fib_state_t : generator state, RUN (normal advance) or SAT (clamped at all-ones)
//   FIB_WRAP    : overflow wraps modulo 2^WIDTH
//   FIB_SAT     : overflow clamps to all-ones and parks the generator in SAT
package fib_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SAT = 1'b1
  } fib_state_t;

  localparam logic FIB_WRAP = 1'b0;
  localparam logic FIB_SAT  = 1'b1;

endpackage

// File: rtl/fib_step.sv
// Combinational next-pair logic for the Fibonacci source.
// Ports:
//   a, b       : current sequence pair (A is the emitted term)
//   mode       : FIB_WRAP or FIB_SAT overflow handling
//   state      : current generator state
//   a_nxt      : next A (always the old B)
//   b_nxt      : next B (sum, wrapped or clamped)
//   carry      : carry out of the WIDTH-bit addition
//   state_nxt  : next generator state
module fib_step
  import fib_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  fib_state_t       state,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             carry,
  output fib_state_t       state_nxt
);

  logic [WIDTH:0] sum;

  // Clamp the WIDTH+1 bit sum to WIDTH bits: all-ones when clamping is
  // requested, the plain low bits otherwise.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH:0] s, input logic clamp);
    if (clamp) begin
      sat_sum = '1;
    end else begin
      sat_sum = s[WIDTH-1:0];
    end
  endfunction

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    carry     = sum[WIDTH];
    a_nxt     = b;
    state_nxt = state;
    b_nxt     = sat_sum(sum, 1'b0);
    if (state == SAT) begin
      // Parked: B stays pinned so A converges to all-ones.
      b_nxt = sat_sum(sum, 1'b1);
    end else if (carry && (mode == FIB_SAT)) begin
      b_nxt     = sat_sum(sum, 1'b1);
      state_nxt = SAT;
    end
  end

endmodule

// File: rtl/fib_stream.sv
// Parametrised Fibonacci pattern source with a valid/ready output stream.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-low reset
//   en         : request to keep producing beats
//   load       : synchronous seed load (load_a -> A, load_b -> B)
//   load_a     : new A value
//   load_b     : new B value
//   out_ready  : consumer ready
//   out_valid  : beat present
//   out_data   : current term (register A)
//   overflow   : sticky, set when an advance carried out of WIDTH bits
//   saturated  : generator parked in SAT
//   count      : beats transferred since reset or load (wraps)
module fib_stream
  import fib_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int COUNT_W  = 16,
  parameter int SEED0    = 0,
  parameter int SEED1    = 1,
  parameter int SATURATE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_a,
  input  logic [WIDTH-1:0]   load_b,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               overflow,
  output logic               saturated,
  output logic [COUNT_W-1:0] count
);

  localparam logic MODE = (SATURATE != 0) ? FIB_SAT : FIB_WRAP;

  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  fib_state_t       state;

  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic             carry;
  fib_state_t       state_nxt;
  logic             fire;
  logic             valid_nxt;

  fib_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a        (reg_a),
    .b        (reg_b),
    .mode     (MODE),
    .state    (state),
    .a_nxt    (a_nxt),
    .b_nxt    (b_nxt),
    .carry    (carry),
    .state_nxt(state_nxt)
  );

  assign fire     = out_valid & out_ready;
  assign out_data = reg_a;

  // After a transfer, valid follows en; otherwise en can raise valid but a
  // pending beat is never withdrawn.
  assign valid_nxt = fire ? en : (out_valid | en);

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_a     <= WIDTH'(SEED0);
      reg_b     <= WIDTH'(SEED1);
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      saturated <= 1'b0;
      count     <= '0;
      state     <= RUN;
    end else if (load) begin
      // A beat transferred on this edge is dropped from the count.
      reg_a     <= load_a;
      reg_b     <= load_b;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      saturated <= 1'b0;
      count     <= '0;
      state     <= RUN;
    end else begin
      out_valid <= valid_nxt;
      if (fire) begin
        reg_a     <= a_nxt;
        reg_b     <= b_nxt;
        state     <= state_nxt;
        saturated <= (state_nxt == SAT);
        count     <= count + COUNT_W'(1);
        if (carry) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
